// File: rtl/pred_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Holds opcode/counter constants, the in-flight entry layout and saturating counter updates.
package pred_pkg;

  localparam int P_INSTR_W    = 14;
  localparam int P_PC_W       = 11;
  localparam int P_IDX_W      = 4;
  localparam int P_INFL_DEPTH = 4;

  localparam logic [2:0] OP_JMP = 3'b100;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] P_CTR_INIT = WNT;

  typedef struct packed {
    logic [P_IDX_W-1:0] idx;
    logic               pred;
    logic [P_PC_W-1:0]  target;
    logic [P_PC_W-1:0]  fallthru;
  } infl_entry_t;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/pred_inflight_fifo.sv
// In-order queue of unresolved conditional predictions; flush empties it and beats a same-cycle push.
// Push when full and pop when empty are ignored; count is registered.
module pred_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int DAT_W = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [DAT_W-1:0] i_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [DAT_W-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [DAT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dat   = r_mem[r_rd];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

  // Pointers are power-of-two wide, so increment wraps modulo DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage predictor: jumps resolve at once, conditionals use 2-bit counters and queue until execute resolves them.
// Prediction is combinational; mispredict/redirect registered one cycle after resolution; stall when queue full.
module branch_predict_unit
  import pred_pkg::*;
#(
  parameter int         INSTR_W    = P_INSTR_W,
  parameter int         PC_W       = P_PC_W,
  parameter int         IDX_W      = P_IDX_W,
  parameter int         INFL_DEPTH = P_INFL_DEPTH,
  parameter logic [1:0] CTR_INIT   = P_CTR_INIT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_fetch_valid,
  input  logic [INSTR_W-1:0]            i_instr,
  input  logic [PC_W-1:0]               i_pc,
  output logic [PC_W-1:0]               o_next,
  output logic                          o_predict_taken,
  output logic                          o_enable,
  output logic                          o_stall,
  input  logic                          i_res_valid,
  input  logic                          i_res_taken,
  output logic                          o_mispredict,
  output logic [PC_W-1:0]               o_redirect_pc,
  output logic [$clog2(INFL_DEPTH):0]   o_pending_count,
  output logic                          o_err_underflow
);

  localparam int ENT_W = $bits(infl_entry_t);

  logic [1:0]       r_table [2**IDX_W];
  logic             r_mispredict;
  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_err_underflow;

  logic [2:0]       w_op;
  logic             w_is_jmp;
  logic             w_is_cond;
  logic [PC_W-1:0]  w_target;
  logic [IDX_W-1:0] w_idx;
  logic             w_pred;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_resolve;
  logic             w_wrong;
  infl_entry_t      w_push_ent;
  infl_entry_t      w_head;
  logic [ENT_W-1:0] w_head_dat;

  assign w_op      = i_instr[INSTR_W-1 -: 3];
  assign w_is_jmp  = (w_op == OP_JMP);
  assign w_is_cond = w_op[2] & ~w_is_jmp;
  assign w_target  = i_instr[PC_W-1:0];
  assign w_idx     = i_pc[IDX_W-1:0];
  assign w_pred    = r_table[w_idx][1];

  assign w_push     = ~i_rst & i_fetch_valid & w_is_cond & ~w_full;
  assign w_resolve  = ~i_rst & i_res_valid & ~w_empty;
  assign w_head     = infl_entry_t'(w_head_dat);
  assign w_wrong    = w_resolve & (i_res_taken != w_head.pred);
  assign w_push_ent = '{idx: w_idx, pred: w_pred, target: w_target, fallthru: i_pc};

  always_comb begin
    o_next          = i_pc;
    o_predict_taken = 1'b0;
    o_enable        = 1'b0;
    o_stall         = 1'b0;
    if (!i_rst) begin
      if (w_is_jmp) begin
        o_next          = w_target;
        o_predict_taken = 1'b1;
      end else if (w_is_cond) begin
        o_next          = w_pred ? w_target : i_pc;
        o_predict_taken = w_pred;
        o_enable        = 1'b1;
        o_stall         = i_fetch_valid & w_full;
      end
    end
  end

  // A wrong prediction flushes younger wrong-path entries, including one pushed this cycle.
  pred_inflight_fifo #(
    .DEPTH (INFL_DEPTH),
    .DAT_W (ENT_W)
  ) u_inflight (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_dat   (w_push_ent),
    .i_pop   (w_resolve),
    .i_flush (w_wrong),
    .o_dat   (w_head_dat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_pending_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2**IDX_W; i++) r_table[i] <= CTR_INIT;
      r_mispredict    <= 1'b0;
      r_redirect_pc   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_mispredict <= w_wrong;
      if (w_resolve)
        r_table[w_head.idx] <= i_res_taken ? ctr_inc(r_table[w_head.idx])
                                           : ctr_dec(r_table[w_head.idx]);
      if (w_wrong)
        r_redirect_pc <= i_res_taken ? w_head.target : w_head.fallthru;
      if (i_res_valid && w_empty)
        r_err_underflow <= 1'b1;
    end
  end

  assign o_mispredict    = r_mispredict;
  assign o_redirect_pc   = r_redirect_pc;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: immediate checks on prediction outputs, plus a scoreboard queue of expected
// redirect PCs that a negedge monitor pops whenever the mispredict pulse appears.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [13:0] instr;
  logic [10:0] pc;
  logic [10:0] next;
  logic        predict_taken;
  logic        enable;
  logic        stall;
  logic        res_valid;
  logic        res_taken;
  logic        mispredict;
  logic [10:0] redirect_pc;
  logic [2:0]  pending_count;
  logic        err_underflow;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fetch_valid   (fetch_valid),
    .i_instr         (instr),
    .i_pc            (pc),
    .o_next          (next),
    .o_predict_taken (predict_taken),
    .o_enable        (enable),
    .o_stall         (stall),
    .i_res_valid     (res_valid),
    .i_res_taken     (res_taken),
    .o_mispredict    (mispredict),
    .o_redirect_pc   (redirect_pc),
    .o_pending_count (pending_count),
    .o_err_underflow (err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [10:0] e;
    if (mispredict !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mispredict: got mispredict=%b redirect=%0h expected no pulse",
                 mispredict, redirect_pc);
      end else begin
        e = exp_q.pop_front();
        chk("redirect_pc", 32'(redirect_pc), 32'(e));
      end
    end
  end

  initial begin
    bit exp_pt [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit act_tk [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; fetch_valid = 1'b1; instr = 14'h0123; pc = 11'h045;
    res_valid = 1'b0; res_taken = 1'b0;
    tick(); tick();
    chk("rst_pending", 32'(pending_count), 0);
    chk("rst_err", 32'(err_underflow), 0);
    rst = 1'b0;
    #1;
    chk("seq_next", 32'(next), 32'h045);
    chk("seq_pt", 32'(predict_taken), 0);
    chk("seq_en", 32'(enable), 0);

    // Unconditional jump
    instr = {3'b100, 11'h2A0};
    #1;
    chk("jmp_next", 32'(next), 32'h2A0);
    chk("jmp_pt", 32'(predict_taken), 1);
    chk("jmp_en", 32'(enable), 0);
    tick();
    chk("jmp_nopush", 32'(pending_count), 0);

    // Conditional predicted not-taken, resolved taken
    instr = {3'b101, 11'h300}; pc = 11'h011;
    #1;
    chk("cond_next", 32'(next), 32'h011);
    chk("cond_en", 32'(enable), 1);
    chk("cond_stall", 32'(stall), 0);
    tick();
    chk("cond_push", 32'(pending_count), 1);
    fetch_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
    exp_q.push_back(11'h300);
    tick();
    res_valid = 1'b0;
    chk("cond_pop", 32'(pending_count), 0);
    #1;
    chk("refetch_next", 32'(next), 32'h300);
    chk("refetch_pt", 32'(predict_taken), 1);

    // Fill queue, then stall
    fetch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 11'h022 + 11'(i) * 11'h011;
      instr = {3'b101, 11'h100};
      tick();
    end
    chk("fill_count", 32'(pending_count), 4);
    pc = 11'h066;
    #1;
    chk("full_stall", 32'(stall), 1);
    tick();
    chk("full_nopush", 32'(pending_count), 4);
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    #1;
    chk("after_pop_count", 32'(pending_count), 3);
    chk("after_pop_stall", 32'(stall), 0);

    // Oldest mispredicts while a new conditional is pushed
    res_valid = 1'b1; res_taken = 1'b1;
    exp_q.push_back(11'h100);
    tick();
    res_valid = 1'b0; fetch_valid = 1'b0;
    chk("flush_count", 32'(pending_count), 0);
    tick();
    chk("flush_hold", 32'(pending_count), 0);

    // Underflow is sticky
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("underflow_set", 32'(err_underflow), 1);
    tick();
    chk("underflow_hold", 32'(err_underflow), 1);
    chk("underflow_count", 32'(pending_count), 0);

    // Saturation at strongly taken
    pc = 11'h077; instr = {3'b101, 11'h1AB};
    for (int i = 0; i < 6; i++) begin
      fetch_valid = 1'b1;
      #1;
      chk($sformatf("sat_pt%0d", i), 32'(predict_taken), 32'(exp_pt[i]));
      tick();
      fetch_valid = 1'b0; res_valid = 1'b1; res_taken = act_tk[i];
      if (act_tk[i] != exp_pt[i]) exp_q.push_back(act_tk[i] ? 11'h1AB : 11'h077);
      tick();
      res_valid = 1'b0;
    end
    #1;
    chk("sat_after_dec_pt", 32'(predict_taken), 1);
    chk("sat_after_dec_next", 32'(next), 32'h1AB);

    // Reset forces outputs and clears state
    fetch_valid = 1'b1; rst = 1'b1;
    #1;
    chk("rst_force_next", 32'(next), 32'h077);
    chk("rst_force_en", 32'(enable), 0);
    chk("rst_force_pt", 32'(predict_taken), 0);
    tick();
    rst = 1'b0; fetch_valid = 1'b0;
    #1;
    chk("rst_clr_err", 32'(err_underflow), 0);
    chk("rst_clr_misp", 32'(mispredict), 0);
    chk("rst_clr_ctr_pt", 32'(predict_taken), 0);
    chk("rst_clr_next", 32'(next), 32'h077);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
